// File: rtl/fsb_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsb_ctrl_if                                                  |
// | Description : 68HC000 front-side-bus pin bundle between CPU and controller.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface fsb_ctrl_if #(
  parameter int NTO = 2
);
  logic           nAS;
  logic           Ready;
  logic           nDTACK;
  logic           nBERR;
  logic           ASActive;
  logic           ASInactive;
  logic [NTO-1:0] Timeout;
  logic [3:0]     WaitCnt;

  // CPU / ready-logic side
  modport master (
    output nAS, Ready,
    input  nDTACK, nBERR, ASActive, ASInactive, Timeout, WaitCnt
  );

  // Cycle controller side
  modport slave (
    input  nAS, Ready,
    output nDTACK, nBERR, ASActive, ASInactive, Timeout, WaitCnt
  );
endinterface
`default_nettype wire

// File: rtl/fsb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsb_ctrl                                                     |
// | Description : 68HC000 bus cycle controller: wait states, DTACK, BERR timeout|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fsb_ctrl #(
  parameter int REF_W   = 6,
  parameter int NTO     = 2,
  parameter int MINWS   = 0,
  parameter int BERR_EN = 1
) (
  input  logic      FCLK,
  input  logic      nRES,
  fsb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_BERR = 2'd3
  } state_t;

  localparam logic [3:0] c_MINWS   = 4'(MINWS);
  localparam logic       c_BERR_EN = (BERR_EN != 0);

  logic             r_asrf;
  logic [REF_W-1:0] r_refcnt;
  logic [3:0]       r_waitcnt;
  logic [NTO-1:0]   r_timeout;
  logic             r_ndtack;
  logic             r_nberr;
  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_as_active;
  logic             w_as_inactive;
  logic             w_tick;
  logic             w_ack_ok;
  logic             w_final_to;
  logic [NTO-1:0]   w_to_set;

  assign w_as_active   = ~bus.nAS;
  assign w_as_inactive = bus.nAS & ~r_asrf;
  assign w_tick        = (r_refcnt == '0);
  assign w_ack_ok      = bus.Ready & w_as_active & (r_waitcnt >= c_MINWS);
  assign w_final_to    = r_timeout[NTO-1] & c_BERR_EN;

  // Falling-edge resample: the strobe only counts as gone once it stayed high across a negedge
  always_ff @(negedge FCLK or negedge nRES) begin
    if (!nRES) r_asrf <= 1'b0;
    else       r_asrf <= ~bus.nAS;
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) r_refcnt <= '0;
    else       r_refcnt <= r_refcnt + REF_W'(1);
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES)                                   r_waitcnt <= 4'd0;
    else if (w_as_inactive)                      r_waitcnt <= 4'd0;
    else if (w_as_active && r_waitcnt != 4'hF)   r_waitcnt <= r_waitcnt + 4'd1;
  end

  // Stage i arms only on a tick after stage i-1 was already set
  generate
    for (genvar gi = 0; gi < NTO; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_to_set[gi] = 1'b1;
      end else begin : g_chain
        assign w_to_set[gi] = r_timeout[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES)                        r_timeout <= '0;
    else if (w_as_inactive)           r_timeout <= '0;
    else if (w_as_active && w_tick)   r_timeout <= r_timeout | w_to_set;
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      r_state  <= S_IDLE;
      r_ndtack <= 1'b1;
      r_nberr  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_ndtack <= (w_state_nxt != S_ACK);
      r_nberr  <= (w_state_nxt != S_BERR);
    end
  end

  // IDLE evaluates the acknowledge condition too, so MINWS=0 acks on the first AS edge.
  // A vanished strobe takes priority over a timeout so BERR never fires outside a cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_ack_ok)            w_state_nxt = S_ACK;
        else if (w_as_inactive)  w_state_nxt = S_IDLE;
        else if (w_final_to)     w_state_nxt = S_BERR;
        else if (w_as_active)    w_state_nxt = S_WAIT;
      end
      S_ACK, S_BERR: begin
        if (w_as_inactive)       w_state_nxt = S_IDLE;
      end
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.nDTACK     = r_ndtack;
  assign bus.nBERR      = r_nberr;
  assign bus.ASActive   = w_as_active;
  assign bus.ASInactive = w_as_inactive;
  assign bus.Timeout    = r_timeout;
  assign bus.WaitCnt    = r_waitcnt;

endmodule
`default_nettype wire

// File: tb/tb_fsb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fsb_ctrl                                                  |
// | Description : Two fsb_ctrl instances against a cycle-level reference model.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fsb_ctrl;

  localparam int c_NTO    = 2;
  localparam int c_PERIOD = 8;   // 2**REF_W with REF_W=3

  logic FCLK = 1'b0;
  logic nRES = 1'b0;
  logic nas  = 1'b1;
  logic ready = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Instance A: MINWS=2 with BERR; instance B: MINWS=0, BERR disabled
  fsb_ctrl_if #(.NTO(c_NTO)) bus_a ();
  fsb_ctrl_if #(.NTO(c_NTO)) bus_b ();
  assign bus_a.nAS = nas;
  assign bus_a.Ready = ready;
  assign bus_b.nAS = nas;
  assign bus_b.Ready = ready;

  fsb_ctrl #(.REF_W(3), .NTO(c_NTO), .MINWS(2), .BERR_EN(1)) dut_a (
    .FCLK(FCLK), .nRES(nRES), .bus(bus_a.slave));
  fsb_ctrl #(.REF_W(3), .NTO(c_NTO), .MINWS(0), .BERR_EN(0)) dut_b (
    .FCLK(FCLK), .nRES(nRES), .bus(bus_b.slave));

  always #5 FCLK = ~FCLK;

  // Model: per instance, wait count, timeout ticks seen, and outcome (0 none, 1 acked, 2 bus error)
  int m_wait[2], m_ticks[2], m_out[2];
  int c_minws[2] = '{2, 0};
  int c_berr[2]  = '{1, 0};
  bit m_asrf;
  bit m_act, m_inact;
  int m_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_asrf = 1'b0;
    m_edge = 0;
    for (int d = 0; d < 2; d++) begin
      m_wait[d] = 0; m_ticks[d] = 0; m_out[d] = 0;
    end
  endtask

  task automatic model_posedge();
    bit tick;
    m_act   = !nas;
    m_inact = nas && !m_asrf;
    tick    = (m_edge % c_PERIOD) == 0;
    m_edge++;
    for (int d = 0; d < 2; d++) begin
      if (m_out[d] == 0) begin
        if (m_act && ready && m_wait[d] >= c_minws[d]) m_out[d] = 1;
        else if (!m_inact && c_berr[d] == 1 && m_ticks[d] >= c_NTO) m_out[d] = 2;
      end else if (m_inact) begin
        m_out[d] = 0;
      end
      if (m_inact)     m_wait[d] = 0;
      else if (m_act)  m_wait[d] = (m_wait[d] < 15) ? m_wait[d] + 1 : 15;
      if (m_inact)               m_ticks[d] = 0;
      else if (m_act && tick)    m_ticks[d] = (m_ticks[d] < c_NTO) ? m_ticks[d] + 1 : c_NTO;
    end
  endtask

  task automatic check_all();
    chk("a_ndtack",  bus_a.nDTACK,  m_out[0] != 1);
    chk("a_nberr",   bus_a.nBERR,   m_out[0] != 2);
    chk("a_timeout", bus_a.Timeout, (32'd1 << m_ticks[0]) - 1);
    chk("a_waitcnt", bus_a.WaitCnt, m_wait[0]);
    chk("a_asact",   bus_a.ASActive, m_act);
    chk("a_asinact", bus_a.ASInactive, m_inact);
    chk("b_ndtack",  bus_b.nDTACK,  m_out[1] != 1);
    chk("b_nberr",   bus_b.nBERR,   m_out[1] != 2);
    chk("b_timeout", bus_b.Timeout, (32'd1 << m_ticks[1]) - 1);
    chk("b_waitcnt", bus_b.WaitCnt, m_wait[1]);
  endtask

  // late=1 changes the inputs after the negedge, so the resampler still sees the old strobe
  task automatic step(input logic a, input logic r, input logic late);
    if (late) begin
      m_asrf = !nas;
      @(negedge FCLK); #1;
      nas = a; ready = r;
    end else begin
      nas = a; ready = r;
      m_asrf = !nas;
    end
    @(posedge FCLK); #1;
    model_posedge();
    check_all();
  endtask

  initial begin
    bit found;
    int n1;
    int run;
    bit lowphase;

    // Reset held with a strobe and Ready active
    nRES = 1'b0; nas = 1'b0; ready = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge FCLK); #1;
      chk("rst_ndtack",  bus_a.nDTACK, 1);
      chk("rst_nberr",   bus_a.nBERR, 1);
      chk("rst_timeout", bus_a.Timeout, 0);
      chk("rst_waitcnt", bus_b.WaitCnt, 0);
    end
    nRES = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);

    // Minimum wait states: A acks two edges after the first AS edge, B on the first
    step(0, 1, 0);
    chk("ws_a_k0", bus_a.nDTACK, 1);
    chk("ws_b_k0", bus_b.nDTACK, 0);
    step(0, 1, 0);
    chk("ws_a_k1", bus_a.nDTACK, 1);
    step(0, 1, 0);
    chk("ws_a_k2", bus_a.nDTACK, 0);
    step(1, 1, 0);
    chk("ws_a_release", bus_a.nDTACK, 1);

    // Timeout chain then BERR
    found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      step(0, 0, 0);
      if (bus_a.Timeout[0]) found = 1;
    end
    chk("to0_within_8", found, 1);
    found = 0; n1 = 0;
    for (int i = 1; i <= 16 && !found; i++) begin
      step(0, 0, 0);
      if (bus_a.Timeout[1]) begin found = 1; n1 = i; end
    end
    chk("to1_gap", n1, 8);
    step(0, 0, 0);
    chk("berr_a", bus_a.nBERR, 0);
    chk("berr_b_off", bus_b.nBERR, 1);
    step(1, 0, 0);
    chk("berr_clear_to", bus_a.Timeout, 0);
    chk("berr_clear", bus_a.nBERR, 1);

    // Ready on the edge that sees the final timeout: DTACK wins
    found = 0;
    for (int i = 1; i <= 24 && !found; i++) begin
      step(0, 0, 0);
      if (bus_a.Timeout[1]) found = 1;
    end
    chk("race_to_seen", found, 1);
    step(0, 1, 0);
    chk("race_ndtack", bus_a.nDTACK, 0);
    chk("race_nberr", bus_a.nBERR, 1);
    step(1, 0, 0);

    // Long hang with BERR disabled on B
    repeat (200) step(0, 0, 0);
    chk("hang_b_to", bus_b.Timeout, 3);
    chk("hang_b_nberr", bus_b.nBERR, 1);
    chk("hang_b_ndtack", bus_b.nDTACK, 1);
    step(1, 0, 0);

    // Back-to-back cycles separated by one negedge of nAS high
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("b2b_waitcnt", bus_a.WaitCnt, 1);
    chk("b2b_b_ack", bus_b.nDTACK, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("b2b_a_ack", bus_a.nDTACK, 0);
    step(1, 0, 0);

    // Randomised strobe runs, sparse Ready, occasional late input changes
    run = 0; lowphase = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        lowphase = !lowphase;
        run = lowphase ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 3));
      end
      run--;
      step(!lowphase, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset mid-cycle while A is acknowledging
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    nRES = 1'b0;
    #2;
    chk("midrst_a_ndtack", bus_a.nDTACK, 1);
    chk("midrst_a_waitcnt", bus_a.WaitCnt, 0);
    chk("midrst_b_ndtack", bus_b.nDTACK, 1);
    model_reset();
    @(posedge FCLK); #1;
    nRES = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
